// File: rtl/sift_match_if.sv
// Pixel-stream and match-result bundle for sift_match.
// The testbench drives through master; the matcher consumes through slave.
interface sift_match_if #(
  parameter int DW = 8
);
  logic          valid_in;
  logic [DW-1:0] data_in1;
  logic [DW-1:0] data_in2;
  logic          valid_match;
  logic [31:0]   match_addr;

  modport master (output valid_in, data_in1, data_in2, input valid_match, match_addr);
  modport slave  (input valid_in, data_in1, data_in2, output valid_match, match_addr);
endinterface

// File: rtl/sift_match.sv
// Streaming 3x3 local-maximum keypoint detector for two images, followed by
// brute-force SAD matching of every image-1 keypoint against all image-2 keypoints.
module sift_match #(
  parameter int WIDE      = 256,
  parameter int HIGN      = 256,
  parameter int DW        = 8,
  parameter int MAXKP     = 64,
  parameter int KP_THR    = 16,
  parameter int MATCH_THR = 64
) (
  input logic         clk,
  input logic         rst,
  sift_match_if.slave bus
);
  localparam int CW = (WIDE > 1) ? $clog2(WIDE) : 1;
  localparam int KW = (MAXKP > 1) ? $clog2(MAXKP) : 1;
  localparam int NW = KW + 1;

  typedef enum logic {COLLECT, MATCH} state_t;
  typedef logic [2:0][2:0][DW-1:0] win_t;  // [row][col], row-major patch
  typedef struct packed {
    logic [15:0] addr;
    win_t        pix;
  } kp_t;

  state_t        state;
  logic [15:0]   row, col;
  logic [NW-1:0] n [2];
  logic [KW-1:0] mi, mj, best_j;
  logic [11:0]   best;

  logic [DW-1:0]            lb_a [2][WIDE];  // row r-1
  logic [DW-1:0]            lb_b [2][WIDE];  // row r-2
  logic [1:0][2:0][DW-1:0]  hist [2];        // columns c-2, c-1 of the window
  kp_t                      kp   [2][MAXKP];

  logic [DW-1:0]      pix_in  [2];
  logic [2:0][DW-1:0] new_col [2];
  win_t               win     [2];
  logic               is_kp   [2];
  logic               kp_wr   [2];
  logic               take, eval, frame_end, have_kps;
  logic [15:0]        cen_addr;
  logic [CW-1:0]      ci;

  assign pix_in[0] = bus.data_in1;
  assign pix_in[1] = bus.data_in2;
  assign ci        = col[CW-1:0];
  assign take      = (state == COLLECT) && bus.valid_in;
  // Row/column gating keeps the window from straddling a row wrap or the top border.
  assign eval      = take && (row >= 16'd2) && (col >= 16'd2);
  assign frame_end = take && (row == 16'(HIGN - 1)) && (col == 16'(WIDE - 1));
  assign cen_addr  = (row - 16'd1) * 16'(WIDE) + (col - 16'd1);
  assign have_kps  = ((n[0] != '0) || kp_wr[0]) && ((n[1] != '0) || kp_wr[1]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      new_col[m] = {pix_in[m], lb_a[m][ci], lb_b[m][ci]};
      win[m]     = '0;
      for (int r = 0; r < 3; r++) begin
        win[m][r][0] = hist[m][0][r];
        win[m][r][1] = hist[m][1][r];
        win[m][r][2] = new_col[m][r];
      end
      is_kp[m] = (win[m][1][1] >= DW'(KP_THR));
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          if (!(r == 1 && c == 1) && (win[m][r][c] >= win[m][1][1]))
            is_kp[m] = 1'b0;
      kp_wr[m] = eval && is_kp[m] && (n[m] < NW'(MAXKP));
    end
  end

  function automatic logic [11:0] patch_sad(input win_t a, input win_t b);
    logic [11:0] acc;
    // NOTE: blocking '=' belongs in combinational code and functions; clocked state uses '<='.
    acc = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        acc = acc + 12'((a[r][c] > b[r][c]) ? a[r][c] - b[r][c] : b[r][c] - a[r][c]);
    return acc;
  endfunction

  logic [11:0]   sad, best_c;
  logic [KW-1:0] bj_c;
  logic          last_i, last_j, accept;

  always_comb begin
    sad    = patch_sad(kp[0][mi].pix, kp[1][mj].pix);
    best_c = best;
    bj_c   = best_j;
    if (sad < best) begin  // strict compare: ties keep the lowest j
      best_c = sad;
      bj_c   = mj;
    end
    last_j = ({1'b0, mj} == n[1] - NW'(1));
    last_i = ({1'b0, mi} == n[0] - NW'(1));
    accept = (best_c <= 12'(MATCH_THR));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= COLLECT;
      row             <= '0;
      col             <= '0;
      n[0]            <= '0;
      n[1]            <= '0;
      mi              <= '0;
      mj              <= '0;
      best            <= '1;
      best_j          <= '0;
      bus.valid_match <= 1'b0;
      bus.match_addr  <= '0;
    end else begin
      bus.valid_match <= 1'b0;
      case (state)
        COLLECT: begin
          if (take) begin
            for (int m = 0; m < 2; m++)
              if (kp_wr[m]) n[m] <= n[m] + NW'(1);
            if (frame_end) begin
              row    <= '0;
              col    <= '0;
              mi     <= '0;
              mj     <= '0;
              best   <= '1;
              best_j <= '0;
              if (have_kps) begin
                state <= MATCH;
              end else begin
                n[0] <= '0;
                n[1] <= '0;
              end
            end else if (col == 16'(WIDE - 1)) begin
              col <= '0;
              row <= row + 16'd1;
            end else begin
              col <= col + 16'd1;
            end
          end
        end
        MATCH: begin
          if (last_j) begin
            bus.valid_match <= accept;
            if (accept) bus.match_addr <= {kp[1][bj_c].addr, kp[0][mi].addr};
            best <= '1;
            mj   <= '0;
            if (last_i) begin
              state <= COLLECT;
              mi    <= '0;
              n[0]  <= '0;
              n[1]  <= '0;
            end else begin
              mi <= mi + KW'(1);
            end
          end else begin
            best   <= best_c;
            best_j <= bj_c;
            mj     <= mj + KW'(1);
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // NOTE: line buffers, window history and keypoint tables have no reset; every
  // entry is written before it is read, and a reset would force them into flops.
  always_ff @(posedge clk) begin
    if (take) begin
      for (int m = 0; m < 2; m++) begin
        lb_b[m][ci] <= lb_a[m][ci];
        lb_a[m][ci] <= pix_in[m];
        hist[m][0]  <= hist[m][1];
        hist[m][1]  <= new_col[m];
        if (kp_wr[m]) kp[m][n[m][KW-1:0]] <= '{addr: cen_addr, pix: win[m]};
      end
    end
  end
endmodule

// File: tb/tb_sift_match.sv
// Self-checking bench for sift_match: directed image scenarios plus random frames,
// checked against an image-level keypoint/SAD reference model.
module tb_sift_match;
  localparam int WIDE      = 32;
  localparam int HIGN      = 16;
  localparam int DW        = 8;
  localparam int MAXKP     = 64;
  localparam int KP_THR    = 16;
  localparam int MATCH_THR = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sift_match_if #(.DW(DW)) bus ();

  sift_match #(
    .WIDE(WIDE), .HIGN(HIGN), .DW(DW), .MAXKP(MAXKP),
    .KP_THR(KP_THR), .MATCH_THR(MATCH_THR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] img1 [HIGN][WIDE];
  logic [DW-1:0] img2 [HIGN][WIDE];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_edge;

  int          pul_cyc  [$];
  logic [31:0] pul_addr [$];
  int          exp_off  [$];
  logic [31:0] exp_addr [$];
  int          m_n1, m_n2;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (bus.valid_match === 1'b1) begin
      pul_cyc.push_back(cyc);
      pul_addr.push_back(bus.match_addr);
    end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pix(input bit second, input int r, input int c);
    return second ? int'(img2[r][c]) : int'(img1[r][c]);
  endfunction

  function automatic bit model_kp(input bit second, input int r, input int c);
    int ctr;
    if (r < 1 || r > HIGN - 2 || c < 1 || c > WIDE - 2) return 1'b0;
    ctr = pix(second, r, c);
    if (ctr < KP_THR) return 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if ((dr != 0 || dc != 0) && pix(second, r + dr, c + dc) >= ctr) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int model_sad(input int a1, input int a2);
    int s, d;
    s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        d = pix(0, a1 / WIDE + dr, a1 % WIDE + dc) - pix(1, a2 / WIDE + dr, a2 % WIDE + dc);
        s += (d < 0) ? -d : d;
      end
    return s;
  endfunction

  task automatic build_model();
    int k1 [$];
    int k2 [$];
    int best, bj, s;
    for (int r = 0; r < HIGN; r++)
      for (int c = 0; c < WIDE; c++) begin
        if (model_kp(0, r, c) && k1.size() < MAXKP) k1.push_back(r * WIDE + c);
        if (model_kp(1, r, c) && k2.size() < MAXKP) k2.push_back(r * WIDE + c);
      end
    m_n1 = k1.size();
    m_n2 = k2.size();
    exp_off.delete();
    exp_addr.delete();
    if (m_n1 == 0 || m_n2 == 0) return;
    for (int i = 0; i < m_n1; i++) begin
      best = 1 << 30;
      bj   = 0;
      for (int j = 0; j < m_n2; j++) begin
        s = model_sad(k1[i], k2[j]);
        if (s < best) begin
          best = s;
          bj   = j;
        end
      end
      if (best <= MATCH_THR) begin
        exp_addr.push_back((32'(k2[bj]) << 16) | 32'(k1[i]));
        exp_off.push_back((i + 1) * m_n2);
      end
    end
  endtask

  task automatic fill(input int v1, input int v2);
    for (int r = 0; r < HIGN; r++)
      for (int c = 0; c < WIDE; c++) begin
        img1[r][c] = 8'(v1);
        img2[r][c] = 8'(v2);
      end
  endtask

  task automatic stream(input bit toggle);
    pul_cyc.delete();
    pul_addr.delete();
    for (int r = 0; r < HIGN; r++)
      for (int c = 0; c < WIDE; c++) begin
        if (toggle) begin
          @(negedge clk);
          bus.valid_in = 1'b0;
          bus.data_in1 = 8'($urandom);
          bus.data_in2 = 8'($urandom);
        end
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.data_in1 = img1[r][c];
        bus.data_in2 = img2[r][c];
      end
    @(negedge clk);
    last_edge    = cyc;
    bus.valid_in = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    repeat (m_n1 * m_n2 + 4) @(negedge clk);
    check({tag, "_count"}, 32'(pul_addr.size()), 32'(exp_addr.size()));
    for (int k = 0; k < pul_addr.size() && k < exp_addr.size(); k++) begin
      check({tag, "_addr"}, pul_addr[k], exp_addr[k]);
      check({tag, "_time"}, 32'(pul_cyc[k] - last_edge), 32'(exp_off[k]));
    end
  endtask

  task automatic single_peak();
    fill(0, 0);
    img1[10][20] = 8'd200;
    img2[10][20] = 8'd200;
  endtask

  task automatic many_peaks();
    int r, c, v;
    fill(0, 0);
    for (int k = 0; k < 70; k++) begin
      r = 1 + 2 * (k / 15);
      c = 1 + 2 * (k % 15);
      v = int'($urandom_range(255, 20));
      img1[r][c] = 8'(v);
      img2[r][c] = 8'(v);
    end
  endtask

  initial begin
    int v;
    rst          = 1'b1;
    bus.valid_in = 1'b0;
    bus.data_in1 = '0;
    bus.data_in2 = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(bus.valid_match), 32'd0);
    check("reset_addr", bus.match_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Flat images: no keypoints anywhere.
    fill(8'h40, 8'h40);
    build_model();
    stream(1'b0);
    check_frame("flat");
    check("flat_none", 32'(pul_addr.size()), 32'd0);

    // Single identical peak at (10,20).
    single_peak();
    build_model();
    stream(1'b0);
    check_frame("single");
    check("single_hold", bus.match_addr, 32'h0154_0154);

    // Image 2 shifted right by 5 columns with a random neighbourhood.
    fill(0, 0);
    img1[10][20] = 8'd200;
    img2[10][25] = 8'd200;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (dr != 0 || dc != 0) begin
          v = int'($urandom_range(100, 0));
          img1[10 + dr][20 + dc] = 8'(v);
          img2[10 + dr][25 + dc] = 8'(v);
        end
    build_model();
    stream(1'b0);
    check_frame("shift");
    check("shift_hold", bus.match_addr, 32'h0159_0154);

    // Peak below the keypoint threshold.
    fill(0, 0);
    img1[10][20] = 8'd10;
    img2[10][20] = 8'd10;
    build_model();
    stream(1'b0);
    check_frame("low_peak");

    // Peaks on column 0 and on the last row.
    fill(0, 0);
    img1[5][0] = 8'd200;
    img2[5][0] = 8'd200;
    img1[HIGN - 1][9] = 8'd200;
    img2[HIGN - 1][9] = 8'd200;
    build_model();
    stream(1'b0);
    check_frame("border");

    // Patches differing by SAD 200: rejected.
    fill(0, 0);
    img1[8][8] = 8'd200;
    img2[8][8] = 8'd200;
    img2[7][7] = 8'd100;
    img2[9][9] = 8'd100;
    build_model();
    stream(1'b0);
    check_frame("sad200");

    // Single peak again with valid_in gaps every other cycle.
    single_peak();
    build_model();
    stream(1'b1);
    check_frame("toggle");
    check("toggle_hold", bus.match_addr, 32'h0154_0154);

    // Random image 1, image 2 = image 1 plus small noise.
    for (int r = 0; r < HIGN; r++)
      for (int c = 0; c < WIDE; c++) begin
        img1[r][c] = 8'($urandom);
        v = int'(img1[r][c]) + int'($urandom_range(2, 0));
        img2[r][c] = 8'((v > 255) ? 255 : v);
      end
    build_model();
    stream(1'b0);
    check_frame("rand_corr");

    // Independent random images.
    for (int r = 0; r < HIGN; r++)
      for (int c = 0; c < WIDE; c++) begin
        img1[r][c] = 8'($urandom);
        img2[r][c] = 8'($urandom);
      end
    build_model();
    stream(1'b0);
    check_frame("rand_ind");

    // 70 peaks per image: table saturates at MAXKP.
    many_peaks();
    build_model();
    stream(1'b0);
    check_frame("sat70");

    // Reset in the middle of MATCH aborts the frame.
    many_peaks();
    build_model();
    stream(1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(bus.valid_match), 32'd0);
    check("abort_addr", bus.match_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (MAXKP * MAXKP + 4) @(negedge clk);
    check("abort_pulses", 32'(pul_addr.size()), 32'd0);
    check("abort_hold", bus.match_addr, 32'd0);

    // Clean frame after the abort.
    single_peak();
    build_model();
    stream(1'b0);
    check_frame("after_rst");
    check("after_rst_hold", bus.match_addr, 32'h0154_0154);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sift_match.md
Name: sift_match

Overview:
- Streaming keypoint matcher for the SIFT fusion path.
- Accepts two equal-size 8-bit images pixel-by-pixel in raster order, in parallel.
- Detects 3x3 local-maximum keypoints in each image and stores a 3x3 patch descriptor for each.
- After the frame, pairs every image-1 keypoint with its best image-2 keypoint by SAD and emits each accepted pair as a one-cycle pulse carrying both pixel addresses.

Parameters:
- WIDE, 256, image width in pixels.
- HIGN, 256, image height in pixels. WIDE*HIGN must be at most 65536.
- DW, 8, pixel width.
- MAXKP, 64, keypoint table depth per image.
- KP_THR, 16, minimum centre value for a keypoint.
- MATCH_THR, 64, maximum SAD for an accepted match.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- valid_in  in  1  data_in1/data_in2 carry a pixel this cycle.
- data_in1  in  DW  image-1 pixel.
- data_in2  in  DW  image-2 pixel.
- valid_match  out  1  one-cycle pulse: match_addr is valid.
- match_addr  out  32  [31:16] image-2 address; [15:0] image-1 address. Address = row*WIDE + col.

Behaviour:
- Reset (async, rst=1):
  - valid_match=0, match_addr=0.
  - Pixel counter, row/col counters, keypoint counts n1/n2 and match indices cleared.
  - State goes to COLLECT. Line-buffer contents are don't-care.
- COLLECT state:
  - Pixel is consumed only on cycles with valid_in=1; gaps stall everything.
  - Per image: two WIDE-deep line buffers plus 3x3 window registers.
  - When pixel (r,c) is consumed with r>=2 and c>=2, evaluate the centre at (r-1,c-1).
  - Keypoint if the centre is strictly greater than all 8 neighbours and centre >= KP_THR.
  - Border rows and columns are never keypoints.
  - On a keypoint, write {addr, nine pixels row-major} to that image's table at index n, then n++.
  - When n==MAXKP, further keypoints are dropped (saturate).
  - The images are evaluated independently.
  - The window must not wrap across rows: the evaluation at c<2 is suppressed.
- Frame end: when the WIDE*HIGN-th pixel is consumed, go to MATCH on the next cycle with i=0, j=0, best=max.
  - If n1==0 or n2==0, skip MATCH, clear counters and return to COLLECT.
- MATCH state, one candidate pair per cycle:
  - sad = sum over 9 positions of |p1-p2| (12-bit unsigned).
  - If sad < best, update best and best_j. Ties keep the lowest j.
  - When j==n2-1:
    - Next cycle: if final best <= MATCH_THR, valid_match=1 and match_addr={addr2[best_j], addr1[i]}.
    - Reset best, j=0, i++.
  - After i==n1-1 completes, clear counters and return to COLLECT for the next frame.
- Timing:
  - MATCH lasts n1*n2 cycles.
  - Each pulse comes exactly 1 cycle after its last comparison.
  - Pulses are emitted in increasing image-1 keypoint order.
- valid_in during MATCH is ignored and pixels are lost.
- valid_match is low in every other cycle. match_addr holds its last value between pulses.
- Multiple image-1 keypoints may map to the same image-2 keypoint; no uniqueness check.
- rst asserted mid-COLLECT or mid-MATCH aborts immediately:
  - Outputs go to 0.
  - The next frame starts cleanly after rst deasserts.

Test Plan:
- Flat images (all 0x40), continuous valid_in → no valid_match pulse ever.
- Both images zero except pixel (10,20)=200 → exactly one pulse, match_addr=0x0A140A14, with 2580 in each half. The pulse occurs 1 cycle after MATCH begins plus 1.
- Image 2 is image 1 shifted right 5 columns, single peak at (10,20) with distinct 3x3 neighbourhood → one pulse, match_addr[15:0]=2580, [31:16]=2585.
- Edge and threshold cases:
  - Peak value 10 (<KP_THR) → no pulse.
  - Peak at column 0 or row HIGN-1 → no pulse.
  - Peaks whose patches differ with SAD 200 → no pulse.
- Same image as the (10,20) case, streamed with valid_in toggling every other cycle → identical single pulse and address.
- Two consecutive frames:
  - 70 peaks per image → only the first 64 stored, at most 64 pulses.
  - Assert rst during MATCH → valid_match stays 0 and match_addr=0.
  - The next frame matches correctly after reset.
